// File: rtl/core_ctrl_pkg.sv
// Shared types for the core sequencer: FSM states, inst_type classes, wb_sel codes.
// Pure declarations and decode helpers; no clocked logic, no latency.
// No flow control here; the req/ack handshakes live in core_ctrl.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        FAULT
    } state_t;

    localparam logic [3:0] INST_NONE   = 4'd0;
    localparam logic [3:0] INST_IMM    = 4'd1;
    localparam logic [3:0] INST_REG    = 4'd2;
    localparam logic [3:0] INST_UPP    = 4'd3;
    localparam logic [3:0] INST_STORE  = 4'd4;
    localparam logic [3:0] INST_LOAD   = 4'd8;
    localparam logic [3:0] INST_JUMP   = 4'd12;
    localparam logic [3:0] INST_EBREAK = 4'd13;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    function automatic logic is_load(input logic [3:0] it);
        return it[3:2] == INST_LOAD[3:2];
    endfunction

    function automatic logic is_store(input logic [3:0] it);
        return it[3:2] == INST_STORE[3:2];
    endfunction

    function automatic logic [1:0] wb_sel_of(input logic [3:0] it);
        logic [1:0] sel;
        sel = WB_ALU;
        if (it == INST_UPP)      sel = WB_IMM;
        else if (is_load(it))    sel = WB_MEM;
        else if (it == INST_JUMP) sel = WB_PC4;
        return sel;
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Sequencer-facing bundle: decoder inputs, imem/dmem req/ack, strobes and status.
// Wires only, zero latency.
// Each req is held until its ack; an ack while the req is low is ignored.
interface core_ctrl_if #(
    parameter int XLEN = 32
);
    logic [3:0]      inst_type;
    logic [XLEN-1:0] jump_target;
    logic            imem_req;
    logic            imem_ack;
    logic [XLEN-1:0] imem_addr;
    logic            ir_we;
    logic            dmem_req;
    logic            dmem_we;
    logic [1:0]      dmem_size;
    logic            dmem_ack;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] pc;
    logic            halted;
    logic            illegal;

    modport master (
        input  inst_type, jump_target, imem_ack, dmem_ack,
        output imem_req, imem_addr, ir_we, dmem_req, dmem_we, dmem_size,
               rf_we, wb_sel, pc, halted, illegal
    );

    modport slave (
        output inst_type, jump_target, imem_ack, dmem_ack,
        input  imem_req, imem_addr, ir_we, dmem_req, dmem_we, dmem_size,
               rf_we, wb_sel, pc, halted, illegal
    );
endinterface

// File: rtl/core_ctrl_perf.sv
// Cycle and retired-instruction counters, present only with CORE_CTRL_PERF_EN.
// Counts take effect one clock after the event.
// No backpressure; both counters freeze while halted.
module core_ctrl_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        halted,
    input  logic        retire,
    output logic [63:0] cycle_count,
    output logic [63:0] instret
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else if (!halted) begin
            cycle_count <= cycle_count + 64'd1;
            if (retire) instret <= instret + 64'd1;
        end
    end
endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; CORE_CTRL_PERF_EN adds perf counters.
// ALU/JALR/store 4 cycles, load 5, plus one per ack wait cycle.
// imem/dmem reqs held until ack; EBREAK, illegal type or misaligned jump stop the core.
module core_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input logic         clock,
    input logic         reset,
    core_ctrl_if.master bus
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instret
`endif
);
    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic            imem_req_c, dmem_req_c, ir_we_c, rf_we_c;
    logic            retire;
    logic            halted;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_we_c   = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (bus.inst_type == INST_EBREAK)
                    state_nxt = HALT;
                else if (bus.inst_type == INST_NONE || bus.inst_type > INST_EBREAK)
                    state_nxt = FAULT;
                else
                    state_nxt = EXEC;
            end
            EXEC: begin
                if (is_load(bus.inst_type) || is_store(bus.inst_type))
                    state_nxt = MEM;
                else if (bus.inst_type == INST_JUMP && bus.jump_target[1])
                    state_nxt = FAULT;
                else
                    state_nxt = WB;
            end
            MEM: begin
                dmem_req_c = 1'b1;
                if (bus.dmem_ack) begin
                    if (is_store(bus.inst_type)) begin
                        pc_nxt    = pc_q + XLEN'(4);
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            WB: begin
                rf_we_c   = 1'b1;
                retire    = 1'b1;
                state_nxt = FETCH;
                if (bus.inst_type == INST_JUMP)
                    pc_nxt = {bus.jump_target[XLEN-1:1], 1'b0};
                else
                    pc_nxt = pc_q + XLEN'(4);
            end
            HALT, FAULT: state_nxt = state;
            default:     state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end

    // Reset forces state to FETCH asynchronously; gating keeps every req and strobe low meanwhile.
    assign bus.imem_req  = imem_req_c & reset;
    assign bus.dmem_req  = dmem_req_c & reset;
    assign bus.dmem_we   = (state == MEM) & bus.inst_type[2] & reset;
    assign bus.ir_we     = ir_we_c & reset;
    assign bus.rf_we     = rf_we_c & reset;
    assign bus.dmem_size = bus.inst_type[1:0];
    assign bus.wb_sel    = wb_sel_of(bus.inst_type);
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign halted        = (state == HALT) || (state == FAULT);
    assign bus.halted    = halted;
    assign bus.illegal   = (state == FAULT);

    logic unused_jt0;
    assign unused_jt0 = bus.jump_target[0];

`ifdef CORE_CTRL_PERF_EN
    core_ctrl_perf u_perf (
        .clock       (clock),
        .reset       (reset),
        .halted      (halted),
        .retire      (retire),
        .cycle_count (cycle_count),
        .instret     (instret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif
endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32 core.
- Owns the PC and the state machine FETCH/DECODE/EXEC/MEM/WB.
- Drives the instruction and data memory req/ack handshakes.
- Pulses the IR, register-file and PC write enables from the decoder's inst_type.
- Stops the core on EBREAK, on an illegal instruction, or on a misaligned jump.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, PC/address width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- inst_type  in  4  class from decoder, valid in DECODE onward.
- jump_target  in  XLEN  ALU result for JALR, valid in EXEC/WB.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- imem_addr  out  XLEN  equals pc.
- ir_we  out  1  latch instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_size  out  2  inst_type[1:0] (0 = byte, 1 = half, 2 = word).
- dmem_ack  in  1  data access complete / load data valid.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM.
- pc  out  XLEN  current PC.
- halted  out  1  sticky stop flag.
- illegal  out  1  sticky; set with halted on a fault stop.

Behaviour:
- Reset (reset=0, async):
  - state=FETCH, pc=RESET_PC, halted=0, illegal=0.
  - All strobes and reqs are 0 immediately, including mid-handshake.
  - First fetch request occurs in the first cycle after release.
- Req/ack/strobe timing:
  - imem_req, dmem_req and dmem_we are Moore outputs of the state.
  - Each req stays high until ack is sampled; an ack in the same cycle the req rises is accepted.
  - An ack while its req is low is ignored.
  - imem_addr, dmem_we and dmem_size are stable while the req is high.
  - ir_we and rf_we are Mealy strobes: 1 only in the cycle they are set, 0 otherwise.
- FETCH: imem_req=1. On imem_ack: ir_we=1 (same cycle), next state DECODE.
- DECODE: one cycle for decoder settle. Branch on inst_type:
  - 13 (EBREAK) -> HALT.
  - 0 or unlisted -> FAULT.
  - Otherwise -> EXEC.
- EXEC: one ALU cycle.
  - Loads (4'b10xx) and stores (4'b01xx) -> MEM.
  - JUMP (12) with jump_target[1]=1 -> FAULT.
  - Otherwise -> WB.
- MEM: dmem_req=1, dmem_we=inst_type[2], dmem_size=inst_type[1:0].
  - Load (4'b10xx) on dmem_ack -> WB.
  - Store (4'b01xx) on dmem_ack: pc<=pc+4, retire, next state FETCH (no WB).
- WB: rf_we=1 for one cycle; pc updated; next state FETCH.
  - wb_sel: IMM (1) and REG (2) -> ALU; UPP (3) -> IMM; load -> MEM; JUMP -> PC+4.
  - pc <= {jump_target[XLEN-1:1],1'b0} for JUMP, else pc+4.
- HALT: halted=1, all reqs 0, pc frozen. Only reset exits.
- FAULT: as HALT, plus illegal=1. pc holds the faulting instruction address.
- Latency with zero-wait acks:
  - ALU, LUI, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle on an ack adds one.
- PC arithmetic wraps modulo 2^XLEN: pc=32'hFFFF_FFFC advances to 0.
- Misaligned data addresses are not checked; the memory side handles them.

Optional Feature:
- Macro: CORE_CTRL_PERF_EN.
- Defined:
  - Adds outputs cycle_count[63:0] and instret[63:0], both reset to 0.
  - cycle_count increments every cycle while halted=0.
  - instret increments on each retirement: WB exit or store MEM ack.
  - Both freeze once halted.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package core_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT}.
  - inst_type constants: NONE=0, IMM=1, REG=2, UPP=3, STORE base 4, LOAD base 8, JUMP=12, EBREAK=13.
  - wb_sel constants.
- Sub-module core_ctrl_perf holds the two counters; instantiated only under CORE_CTRL_PERF_EN.

Test Plan:
- Reset release, imem_ack tied high, inst_type=1:
  - imem_addr=32'h8000_0000 in cycle 1.
  - rf_we high in cycle 4.
  - Next imem_addr=32'h8000_0004.
- Load (inst_type=4'b1010), dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles, dmem_we=0, dmem_size=2.
  - wb_sel=1 with rf_we in the following cycle.
  - Total latency 8 cycles.
- Store (inst_type=4'b0100):
  - dmem_we=1, dmem_size=0.
  - rf_we never asserted.
  - pc advances by 4 on the ack cycle.
- JUMP with jump_target=32'h8000_0101:
  - pc=32'h8000_0100, wb_sel=2.
- JUMP with jump_target=32'h8000_0102:
  - halted=1, illegal=1, pc unchanged, no further imem_req.
- EBREAK (inst_type=13):
  - halted=1, illegal=0.
- Reset asserted while imem_req is high mid-wait:
  - imem_req drops the same cycle.
  - After release, refetch from 32'h8000_0000.
